// File: rtl/seq_window_checker.sv
// seq_window_checker: per-channel temporal checker for "a ##[DLY_MIN:DLY_MAX] b".
// Each channel keeps a DLY_MAX-deep age shift register of pending attempts and
// reports pass/fail pulses, sticky errors and saturating pass/fail counters.
module seq_window_checker #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned DLY_MIN = 2,
    parameter int unsigned DLY_MAX = 2,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [NCH-1:0]   a,
    input  logic [NCH-1:0]   b,
    input  logic [SEL_W-1:0] cnt_sel,
    output logic [NCH-1:0]   pass,
    output logic [NCH-1:0]   fail,
    output logic [NCH-1:0]   err_sticky,
    output logic [NCH-1:0]   busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int unsigned SUM_W = CNT_W + 7;

    // pend_q[c][j] = attempt on channel c that currently has age j
    logic [DLY_MAX-1:0] pend_q   [NCH];
    logic [DLY_MAX-1:0] pend_d   [NCH];
    logic [CNT_W-1:0]   pcnt_q   [NCH];
    logic [CNT_W-1:0]   fcnt_q   [NCH];
    logic [CNT_W-1:0]   pcnt_d   [NCH];
    logic [CNT_W-1:0]   fcnt_d   [NCH];
    logic [6:0]         npass    [NCH];
    logic [6:0]         nfail    [NCH];
    logic [NCH-1:0]     pass_d;
    logic [NCH-1:0]     fail_d;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                                 input logic [6:0] inc);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] lim;
        sum = SUM_W'(cur) + SUM_W'(inc);
        lim = SUM_W'({CNT_W{1'b1}});
        if (sum > lim)
            return {CNT_W{1'b1}};
        else
            return sum[CNT_W-1:0];
    endfunction

    // Age every pending attempt by one edge and resolve those reaching the window
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            logic [DLY_MAX-1:0] surv;
            surv      = '0;
            pend_d[c] = '0;
            pass_d[c] = 1'b0;
            fail_d[c] = 1'b0;
            npass[c]  = '0;
            nfail[c]  = '0;
            if (en) begin
                for (int unsigned j = 0; j < DLY_MAX; j++) begin
                    if (pend_q[c][j]) begin
                        // attempt stored at age j is evaluated at age j+1 on this edge
                        if ((j + 1 >= DLY_MIN) && b[c]) begin
                            pass_d[c] = 1'b1;
                            npass[c]  = npass[c] + 7'd1;
                        end else if (j + 1 == DLY_MAX) begin
                            fail_d[c] = 1'b1;
                            nfail[c]  = nfail[c] + 7'd1;
                        end else begin
                            surv[j] = 1'b1;
                        end
                    end
                end
                // shifting drops the top bit, which can never survive anyway
                pend_d[c] = (surv << 1) | DLY_MAX'(a[c]);
            end
            pcnt_d[c] = sat_add(pcnt_q[c], npass[c]);
            fcnt_d[c] = sat_add(fcnt_q[c], nfail[c]);
        end
    end

    // Register attempt state, pulses, busy flags, counters and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                pend_q[c] <= '0;
                pcnt_q[c] <= '0;
                fcnt_q[c] <= '0;
            end
            pass       <= '0;
            fail       <= '0;
            busy       <= '0;
            err_sticky <= '0;
        end else begin
            pass <= pass_d;
            fail <= fail_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                pend_q[c] <= pend_d[c];
                busy[c]   <= |pend_d[c];
                if (clr) begin
                    pcnt_q[c]     <= '0;
                    fcnt_q[c]     <= '0;
                    err_sticky[c] <= 1'b0;
                end else begin
                    pcnt_q[c]     <= pcnt_d[c];
                    fcnt_q[c]     <= fcnt_d[c];
                    err_sticky[c] <= err_sticky[c] | fail_d[c];
                end
            end
        end
    end

    // Counter readout for the selected channel; out-of-range selects read zero
    always_comb begin
        pass_cnt = '0;
        fail_cnt = '0;
        if (32'(cnt_sel) < NCH) begin
            pass_cnt = pcnt_q[cnt_sel];
            fail_cnt = fcnt_q[cnt_sel];
        end
    end

endmodule

// File: doc/seq_window_checker.md
SEQ_WINDOW_CHECKER -- requirements
Module: seq_window_checker

Interface
REQ-001 Parameter NCH, 2, number of independent channels; 1..16.
REQ-002 Parameter DLY_MIN, 2, earliest cycle offset at which b may satisfy an attempt; 1 <= DLY_MIN <= DLY_MAX.
REQ-003 Parameter DLY_MAX, 2, latest cycle offset at which b may satisfy an attempt; DLY_MAX <= 32. DLY_MIN == DLY_MAX gives the fixed-delay check a ##N b.
REQ-004 Parameter CNT_W, 8, width of the pass and fail counters; 2..32.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  checker enable; 0 = no new attempts, and all pending attempts are dropped.
REQ-008 clr  input  1  synchronous clear of counters and sticky errors.
REQ-009 a  input  NCH  per-channel antecedent; 1 sampled at an edge starts an attempt.
REQ-010 b  input  NCH  per-channel consequent.
REQ-011 cnt_sel  input  max(1,$clog2(NCH))  channel selected for counter readout.
REQ-012 pass  output  NCH  registered one-cycle pulse: at least one attempt on the channel passed at the last edge.
REQ-013 fail  output  NCH  registered one-cycle pulse: at least one attempt on the channel failed at the last edge.
REQ-014 err_sticky  output  NCH  set by any fail; held until clr or rst.
REQ-015 busy  output  NCH  registered; 1 while the channel has any pending attempt.
REQ-016 pass_cnt  output  CNT_W  pass counter of channel cnt_sel; combinational mux of registers.
REQ-017 fail_cnt  output  CNT_W  fail counter of channel cnt_sel; combinational mux of registers.

Function
REQ-018 Attempt semantics: a=1 at edge E0 with en=1 starts an attempt of age 0; at each later edge Ek the age is k.
REQ-019 An attempt passes at the first edge Ek with DLY_MIN <= k <= DLY_MAX and b=1, and is retired there.
REQ-020 An attempt fails at edge E(DLY_MAX) if b=0 at that edge and b was 0 at every earlier edge in the window; it is then retired.
REQ-021 Attempts overlap: each a=1 edge starts an independent attempt, and a single b=1 edge passes every pending attempt inside its window.
REQ-022 The b value at edge E0 never satisfies the attempt started at E0.
REQ-023 pass and fail may both assert on one channel in one cycle when different attempts resolve at the same edge.
REQ-024 Counters add the number of attempts resolved at each edge (popcount, up to DLY_MAX-DLY_MIN+1) and saturate at 2^CNT_W-1, with no wrap.
REQ-025 clr=1 at an edge zeroes all counters and err_sticky; clr has priority over same-edge increments and sets; pending attempts and pass/fail pulses are unaffected.
REQ-026 en=0 at an edge retires all pending attempts without pass or fail; busy is 0 after that edge.
REQ-027 cnt_sel >= NCH reads all-zero counters.
REQ-028 Channels are fully independent; no cross-channel interaction.
REQ-029 Pending state per channel is a DLY_MAX-deep age shift register; no other storage beyond the counters and flags.

Reset
REQ-030 While rst=1: pass, fail, busy and err_sticky are 0, all counters are 0, and all pending attempts are cleared, asynchronously.
REQ-031 rst asserted mid-window discards pending attempts; no pass or fail is reported for them after release.
REQ-032 The first attempt may start at the first rising edge after rst deasserts.

Verification
REQ-033 Setup DLY_MIN=DLY_MAX=2, ch0. a=1 at E1, b=1 at E3 -> pass[0]=1 for one cycle after E3, pass_cnt=1, fail_cnt=0.
REQ-034 Same setup, b=0 at E3 -> fail[0]=1 after E3, err_sticky[0]=1 held; clr at E6 -> err_sticky=0, fail_cnt=0.
REQ-035 Same setup, a=1 at E1 and E2, b=1 at E3 and E4 -> pass pulses after E3 and E4, pass_cnt=2, busy=0 after E4.
REQ-036 Setup DLY_MIN=1, DLY_MAX=3. a=1 at E1 and E2, b=1 only at E3 -> a single pass cycle, pass_cnt=2, no fail.
REQ-037 Setup CNT_W=4, a=1 and b=1 every cycle for 40 cycles -> pass_cnt stays 15 and fail_cnt stays 0.
REQ-038 a=1 at E1, rst pulse between E1 and E2 -> no pass or fail, counters 0. Separately, en=0 at E2 -> busy=0 and no fail after E3.
